alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one ALU (ALU-control decoder plus ALU core) between the two issue lanes of the superscalar pipeline.
- Each cycle it picks at most one lane's request using round-robin.
- It drives the winner's ALUOp, funct and operands to the shared ALU, and registers the ALU result with lane id and tag.
- It sits between the dual-issue stage and the EX/MEM registers, and stalls the losing lane via its grant signal.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 4, destination tag carried with each request.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  lane 0 request valid.
- aluop0  in  2  lane 0 ALUOp.
- funct0  in  6  lane 0 funct field.
- a0, b0  in  DATA_W each  lane 0 operands.
- tag0  in  TAG_W  lane 0 destination tag.
- req1, aluop1, funct1, a1, b1, tag1  in  same widths  lane 1 equivalents.
- gnt0, gnt1  out  1  combinational grant; lane accepted this cycle.
- alu_op  out  2  to shared ALU control.
- alu_funct  out  6  to shared ALU control.
- alu_a, alu_b  out  DATA_W  to shared ALU.
- alu_result  in  DATA_W  combinational result of the shared ALU.
- alu_zero  in  1  zero flag of the shared ALU.
- res_stall  in  1  downstream cannot accept a new result.
- res_valid  out  1  registered result valid.
- res_lane  out  1  lane that produced the result.
- res_tag  out  TAG_W  tag of the result.
- res_data  out  DATA_W  registered ALU result.
- res_zero  out  1  registered zero flag.
- conflict_cnt  out  16  saturating count of cycles with both lanes requesting.

Behaviour:
- Reset (asynchronous, any time): res_valid=0, res_lane=0, res_tag=0, res_data=0, res_zero=0, conflict_cnt=0, rr_ptr=0 (lane 0 favoured). Grant outputs follow reset combinationally, so gnt0=gnt1=0 while reset=1.
- Accept condition: adv = !res_stall || !res_valid. When adv=0, gnt0=gnt1=0 and all result registers hold.
- Arbitration (combinational, when adv=1):
  - Only req0 → gnt0. Only req1 → gnt1.
  - Both → grant the lane equal to rr_ptr.
  - Neither → no grant.
  - Grants are one-hot or zero, never both.
- rr_ptr update: on a cycle where both requested and a grant was issued, rr_ptr <= ~granted lane. Otherwise rr_ptr holds, so a lone requester does not steal priority.
- ALU drive:
  - alu_op/alu_funct/alu_a/alu_b come from the granted lane.
  - With no grant they drive lane rr_ptr's fields, which have no effect since nothing is captured.
  - With no grant alu_op=2'b00 is acceptable.
- Result latency is 1 cycle. On the edge after a grant: res_valid<=1, res_lane<=granted lane, res_tag<=tag, res_data<=alu_result, res_zero<=alu_zero.
- adv=1 with no grant → res_valid<=0; the other result fields hold.
- Lane contract:
  - A lane holds req and all fields stable until its gnt.
  - The arbiter never drops a granted request.
  - Requests withdrawn before grant are simply not serviced.
- Starvation bound: with both lanes requesting continuously and adv=1, grants alternate strictly, so each lane waits at most 1 cycle.
- conflict_cnt: increments on every cycle with req0&req1, whether or not stalled; saturates at 16'hFFFF.
- Reset mid-operation: an in-flight result is discarded (res_valid=0). The next grant after release follows rr_ptr=0.
- res_stall with res_valid=0 does not block acceptance; the empty register accepts.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with res_valid=1 → res_valid, res_data, conflict_cnt go 0 immediately; after release, req0&req1 → gnt0 first.
- Single lane: req0, aluop0=2'b10, funct0=6'b100000, a0=5, b0=7, tag0=3 → gnt0 same cycle; next cycle res_valid=1, res_lane=0, res_tag=3, res_data=12.
- Contention: req0&req1 held for 4 cycles, lane1 sub (funct 100010) 9−9 → grants 0,1,0,1; lane1 result has res_data=0, res_zero=1; conflict_cnt=4.
- Stall: res_valid=1, res_stall=1 for 3 cycles with req1 pending → gnt1=0 throughout, res_data stable; stall drops → gnt1 that cycle, new result next cycle.
- Fairness after idle: lane1 wins a contended cycle, then only req0 for 2 cycles (granted), then both → lane0 granted (rr_ptr unchanged by lone requests).
- Saturation: force 70000 contended cycles → conflict_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one ALU (ALU-control decoder + ALU core) between the two issue lanes
// of the superscalar pipeline. Each cycle at most one lane is granted, chosen
// round-robin when both request. The winner's ALUOp/funct/operands are driven
// to the shared ALU, and the ALU result is registered together with the lane
// id and destination tag. The losing lane is stalled by its grant staying low.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   req0/aluop0/funct0/a0/b0/tag0   lane 0 request and fields
//   req1/aluop1/funct1/a1/b1/tag1   lane 1 request and fields
//   gnt0, gnt1                 combinational grants (one-hot or zero)
//   alu_op, alu_funct          to the shared ALU control decoder
//   alu_a, alu_b               to the shared ALU operands
//   alu_result, alu_zero       combinational outputs of the shared ALU
//   res_stall                  downstream cannot take a new result
//   res_valid/res_lane/res_tag/res_data/res_zero   registered result
//   conflict_cnt               saturating count of cycles with both requesting
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic [1:0]        aluop0,
    input  logic [5:0]        funct0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [TAG_W-1:0]  tag0,

    input  logic              req1,
    input  logic [1:0]        aluop1,
    input  logic [5:0]        funct1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [TAG_W-1:0]  tag1,

    output logic              gnt0,
    output logic              gnt1,

    output logic [1:0]        alu_op,
    output logic [5:0]        alu_funct,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    input  logic              res_stall,
    output logic              res_valid,
    output logic              res_lane,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,

    output logic [15:0]       conflict_cnt
);

    // Lane fields gathered into arrays so the grant logic and the ALU mux
    // can be indexed by lane number.
    logic [1:0]        lane_req;
    logic [1:0]        lane_op    [2];
    logic [5:0]        lane_funct [2];
    logic [DATA_W-1:0] lane_a     [2];
    logic [DATA_W-1:0] lane_b     [2];
    logic [TAG_W-1:0]  lane_tag   [2];

    assign lane_req      = {req1, req0};
    assign lane_op[0]    = aluop0;
    assign lane_op[1]    = aluop1;
    assign lane_funct[0] = funct0;
    assign lane_funct[1] = funct1;
    assign lane_a[0]     = a0;
    assign lane_a[1]     = a1;
    assign lane_b[0]     = b0;
    assign lane_b[1]     = b1;
    assign lane_tag[0]   = tag0;
    assign lane_tag[1]   = tag1;

    logic       rr_ptr_reg;   // lane favoured on the next contended cycle
    logic       adv;          // result register can take a new entry
    logic [1:0] gnt_vec;
    logic       gnt_any;
    logic       both_req;
    logic       sel_lane;

    // An empty result register always accepts, even under res_stall.
    assign adv      = !res_stall || !res_valid;
    assign both_req = req0 && req1;

    // A lane wins if it requests and either the other lane is idle or the
    // round-robin pointer names it. The pointer can name only one lane, so
    // the grants are never both high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign gnt_vec[gi] = !reset && adv && lane_req[gi] &&
                                 (!lane_req[1-gi] || (rr_ptr_reg == 1'(gi)));
        end
    endgenerate

    assign gnt0    = gnt_vec[0];
    assign gnt1    = gnt_vec[1];
    assign gnt_any = |gnt_vec;

    // With no grant the ALU sees lane rr_ptr's fields; nothing is captured,
    // so this only avoids an extra constant mux leg.
    assign sel_lane  = gnt_vec[1] ? 1'b1 : (gnt_vec[0] ? 1'b0 : rr_ptr_reg);
    assign alu_op    = lane_op[sel_lane];
    assign alu_funct = lane_funct[sel_lane];
    assign alu_a     = lane_a[sel_lane];
    assign alu_b     = lane_b[sel_lane];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid    <= 1'b0;
            res_lane     <= 1'b0;
            res_tag      <= '0;
            res_data     <= '0;
            res_zero     <= 1'b0;
            conflict_cnt <= 16'd0;
            rr_ptr_reg   <= 1'b0;
        end else begin
            // Counts contention regardless of stall, saturating at all-ones.
            if (both_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end

            // Only a contended grant moves priority; a lone requester
            // leaves the pointer where it was.
            if (both_req && gnt_any) begin
                rr_ptr_reg <= ~gnt_vec[1];
            end

            if (adv) begin
                res_valid <= gnt_any;
                if (gnt_any) begin
                    res_lane <= sel_lane;
                    res_tag  <= lane_tag[sel_lane];
                    res_data <= alu_result;
                    res_zero <= alu_zero;
                end
            end
        end
    end

endmodule
